// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - instruction sequencing control unit for the 16-bit CPU datapath
module cpu_controller #(
    parameter int PC_WIDTH = 7
) (
    input  logic                Clock,
    input  logic                Reset,
    output logic [PC_WIDTH-1:0] IM_Addr,
    input  logic [15:0]         IM_Data,
    output logic [7:0]          D_Addr,
    output logic                D_Wr,
    output logic                RF_s,
    output logic [3:0]          RF_W_Addr,
    output logic                RF_W_en,
    output logic [3:0]          RF_Ra_Addr,
    output logic [3:0]          RF_Rb_Addr,
    output logic [2:0]          ALU_s0,
    output logic [PC_WIDTH-1:0] PC_out,
    output logic [15:0]         IR_out,
    output logic [3:0]          State_out,
    output logic                Halted
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [PC_WIDTH-1:0] pc;
    logic [15:0]         ir;

    // State register; reset lands in INIT so every strobe drops immediately
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= S_INIT;
        end else begin
            state <= next_state;
        end
    end

    // PC and IR advance only in FETCH; PC wraps modulo 2^PC_WIDTH
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc <= '0;
            ir <= '0;
        end else if (state == S_FETCH) begin
            ir <= IM_Data;
            pc <= pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Next-state selection; unused opcodes fall into NOOP
    always_comb begin
        next_state = S_INIT;
        case (state)
            S_INIT:   next_state = S_FETCH;
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (ir[15:12])
                    4'h1:    next_state = S_STORE;
                    4'h2:    next_state = S_LOAD_A;
                    4'h3:    next_state = S_ADD;
                    4'h4:    next_state = S_SUB;
                    4'h5:    next_state = S_HALT;
                    default: next_state = S_NOOP;
                endcase
            end
            S_LOAD_A: next_state = S_LOAD_B;
            S_NOOP,
            S_LOAD_B,
            S_STORE,
            S_ADD,
            S_SUB:    next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_INIT;
        endcase
    end

    // Moore output decode from state and IR; everything defaults to 0
    always_comb begin
        D_Addr     = 8'd0;
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_Addr  = 4'd0;
        RF_W_en    = 1'b0;
        RF_Ra_Addr = 4'd0;
        RF_Rb_Addr = 4'd0;
        ALU_s0     = 3'd0;
        Halted     = 1'b0;
        case (state)
            S_DECODE: begin
                // read ports see the same addresses the execute state will use
                case (ir[15:12])
                    4'h1: RF_Ra_Addr = ir[3:0];
                    4'h3,
                    4'h4: begin
                        RF_Ra_Addr = ir[11:8];
                        RF_Rb_Addr = ir[7:4];
                    end
                    default: ;
                endcase
            end
            S_LOAD_A: begin
                D_Addr    = ir[11:4];
                RF_s      = 1'b1;
                RF_W_Addr = ir[3:0];
            end
            S_LOAD_B: begin
                D_Addr    = ir[11:4];
                RF_s      = 1'b1;
                RF_W_Addr = ir[3:0];
                RF_W_en   = 1'b1;
            end
            S_STORE: begin
                D_Addr     = ir[11:4];
                RF_Ra_Addr = ir[3:0];
                D_Wr       = 1'b1;
            end
            S_ADD,
            S_SUB: begin
                RF_Ra_Addr = ir[11:8];
                RF_Rb_Addr = ir[7:4];
                RF_W_Addr  = ir[3:0];
                RF_W_en    = 1'b1;
                ALU_s0     = (state == S_ADD) ? 3'd1 : 3'd2;
            end
            S_HALT:   Halted = 1'b1;
            default: ;
        endcase
    end

    assign IM_Addr   = pc;
    assign PC_out    = pc;
    assign IR_out    = ir;
    assign State_out = state;

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - randomized self-checking bench for cpu_controller
`timescale 1ns/1ps
module tb_cpu_controller;

    logic        Clock;
    logic        Reset;
    logic [6:0]  IM_Addr;
    logic [15:0] IM_Data;
    logic [7:0]  D_Addr;
    logic        D_Wr;
    logic        RF_s;
    logic [3:0]  RF_W_Addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_Addr;
    logic [3:0]  RF_Rb_Addr;
    logic [2:0]  ALU_s0;
    logic [6:0]  PC_out;
    logic [15:0] IR_out;
    logic [3:0]  State_out;
    logic        Halted;

    logic [15:0] rom [0:127];
    int          n_checks = 0;
    int          n_pass   = 0;

    cpu_controller #(.PC_WIDTH(7)) dut (
        .Clock(Clock), .Reset(Reset), .IM_Addr(IM_Addr), .IM_Data(IM_Data),
        .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s), .RF_W_Addr(RF_W_Addr),
        .RF_W_en(RF_W_en), .RF_Ra_Addr(RF_Ra_Addr), .RF_Rb_Addr(RF_Rb_Addr),
        .ALU_s0(ALU_s0), .PC_out(PC_out), .IR_out(IR_out),
        .State_out(State_out), .Halted(Halted)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // synchronous instruction ROM
    always @(posedge Clock) IM_Data <= rom[IM_Addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [30:0] pv(int st, int da, int dw, int rs, int wa,
                                       int we, int ra, int rb, int alu, int h);
        return {st[3:0], da[7:0], dw[0], rs[0], wa[3:0], we[0], ra[3:0], rb[3:0], alu[2:0], h[0]};
    endfunction

    function automatic logic [30:0] dut_vec();
        return {State_out, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
                RF_Ra_Addr, RF_Rb_Addr, ALU_s0, Halted};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    // hold reset for two edges, check reset state, release at a falling edge
    task automatic do_reset(input string tag);
        Reset = 1'b1;
        @(posedge Clock);
        @(posedge Clock);
        @(negedge Clock);
        check({tag, "_rst_ctrl"}, {1'b0, dut_vec()}, {1'b0, pv(0,0,0,0,0,0,0,0,0,0)});
        check({tag, "_rst_pc"}, {25'd0, PC_out}, 32'd0);
        check({tag, "_rst_ir"}, {16'd0, IR_out}, 32'd0);
        Reset = 1'b0;
    endtask

    // instruction-level reference: per instruction, the list of cycle outputs it produces
    task automatic run_prog(input string tag, input int max_instr);
        int          pc;
        logic [15:0] instr;
        logic [15:0] ir_prev;
        int          op, a, b, d, mem, dra, drb;
        logic [30:0] q [$];
        bit          halted;
        pc = 0;
        ir_prev = 16'h0000;
        halted = 0;
        check($sformatf("%s_init", tag), {1'b0, dut_vec()}, {1'b0, pv(0,0,0,0,0,0,0,0,0,0)});
        for (int k = 0; k < max_instr && !halted; k++) begin
            instr = rom[pc];
            op  = int'(instr[15:12]);
            a   = int'(instr[11:8]);
            b   = int'(instr[7:4]);
            d   = int'(instr[3:0]);
            mem = int'(instr[11:4]);
            dra = (op == 1) ? d : ((op == 3 || op == 4) ? a : 0);
            drb = (op == 3 || op == 4) ? b : 0;
            q.delete();
            q.push_back(pv(1,0,0,0,0,0,0,0,0,0));
            q.push_back(pv(2,0,0,0,0,0,dra,drb,0,0));
            case (op)
                1: q.push_back(pv(6,mem,1,0,0,0,d,0,0,0));
                2: begin
                    q.push_back(pv(4,mem,0,1,d,0,0,0,0,0));
                    q.push_back(pv(5,mem,0,1,d,1,0,0,0,0));
                end
                3: q.push_back(pv(7,0,0,0,d,1,a,b,1,0));
                4: q.push_back(pv(8,0,0,0,d,1,a,b,2,0));
                5: begin
                    q.push_back(pv(9,0,0,0,0,0,0,0,0,1));
                    q.push_back(pv(9,0,0,0,0,0,0,0,0,1));
                    q.push_back(pv(9,0,0,0,0,0,0,0,0,1));
                    halted = 1;
                end
                default: q.push_back(pv(3,0,0,0,0,0,0,0,0,0));
            endcase
            for (int c = 0; c < q.size(); c++) begin
                @(negedge Clock);
                check($sformatf("%s_i%0d_c%0d_ctrl", tag, k, c), {1'b0, dut_vec()}, {1'b0, q[c]});
                check($sformatf("%s_i%0d_c%0d_pc", tag, k, c), {25'd0, PC_out},
                      (c == 0) ? pc : (pc + 1) % 128);
                check($sformatf("%s_i%0d_c%0d_ir", tag, k, c), {16'd0, IR_out},
                      {16'd0, (c == 0) ? ir_prev : instr});
            end
            pc = (pc + 1) % 128;
            ir_prev = instr;
        end
    endtask

    initial begin
        int          op;
        logic [15:0] w;
        bit          seen;
        Reset = 1'b1;
        clear_rom();

        // NOOP then HALT: state sequence 0,1,2,3,1,2,9 then PC held at 2
        rom[0] = 16'h0000;
        rom[1] = 16'h5000;
        do_reset("halt");
        run_prog("halt", 10);

        // LOAD, ADD, SUB, STORE directed, then halt
        clear_rom();
        rom[0] = 16'h21B3;
        rom[1] = 16'h3125;
        rom[2] = 16'h4125;
        rom[3] = 16'h1AB7;
        rom[4] = 16'h5000;
        do_reset("dir");
        run_prog("dir", 10);

        // random programs ending in HALT, including illegal opcodes
        for (int r = 0; r < 4; r++) begin
            clear_rom();
            for (int i = 0; i < 11; i++) begin
                op = $urandom_range(0, 15);
                while (op == 5) op = $urandom_range(0, 15);
                w = {op[3:0], 12'($urandom_range(0, 4095))};
                rom[i] = w;
            end
            rom[11] = 16'h5000;
            do_reset($sformatf("rnd%0d", r));
            run_prog($sformatf("rnd%0d", r), 20);
        end

        // NOOP-filled ROM with an illegal opcode: PC wraps 127 -> 0 and keeps going
        clear_rom();
        rom[5]   = 16'hF000;
        rom[126] = 16'h9ABC;
        do_reset("wrap");
        run_prog("wrap", 131);

        // reset pulse during LOAD_B drops the write enable at once
        clear_rom();
        rom[0] = 16'h21B3;
        do_reset("midrst");
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge Clock);
            if (State_out == 4'd5) seen = 1;
        end
        check("midrst_reach_load_b", {31'd0, seen}, 32'd1);
        check("midrst_wen_before", {31'd0, RF_W_en}, 32'd1);
        #1 Reset = 1'b1;
        #1;
        check("midrst_wen_drop", {31'd0, RF_W_en}, 32'd0);
        check("midrst_state", {28'd0, State_out}, 32'd0);
        check("midrst_pc", {25'd0, PC_out}, 32'd0);
        #1 Reset = 1'b0;
        @(negedge Clock);
        check("midrst_refetch_state", {28'd0, State_out}, 32'd1);
        check("midrst_refetch_pc", {25'd0, PC_out}, 32'd0);
        @(negedge Clock);
        check("midrst_refetch_ir", {16'd0, IR_out}, 32'h21B3);
        check("midrst_refetch_pc1", {25'd0, PC_out}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
